dmm_port_arbiter: RTL and testbench



---
 rtl/dmm_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_dmm_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmm_port_arbiter.sv
// Round-robin arbiter sharing the dmm_unit memory port between
// the allocator memory master (req0) and the atomic unit (req1).
module dmm_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_strobe_i,
  input  logic [31:0]  req0_addr_i,
  input  logic         req0_rw_i,
  input  logic [255:0] req0_data_i,
  input  logic [7:0]   req0_size_i,
  output logic         req0_done_o,
  output logic [255:0] req0_data_o,
  input  logic         req1_strobe_i,
  input  logic [31:0]  req1_addr_i,
  input  logic         req1_rw_i,
  input  logic [255:0] req1_data_i,
  input  logic [7:0]   req1_size_i,
  output logic         req1_done_o,
  output logic [255:0] req1_data_o,
  output logic         dmm_unit_strobe,
  output logic [31:0]  dmm_unit_addr,
  output logic         dmm_unit_rw,
  output logic [255:0] dmm_unit_dataout,
  output logic [7:0]   dmm_unit_size,
  input  logic         dmm_unit_done,
  input  logic [255:0] dmm_unit_datain,
  output logic         grant_o,
  output logic         busy_o,
  output logic         timeout_o,
  output logic         drop_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LIM =
    CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t         r_state;
  state_t         w_next;
  logic           r_grant;
  logic           w_grant_nxt;
  logic           r_ptr;
  logic [1:0]     r_pend;
  logic [CNT_W-1:0] r_cnt;
  logic           r_timeout;

  logic [31:0]    r_addr0;
  logic           r_rw0;
  logic [255:0]   r_wdat0;
  logic [7:0]     r_size0;
  logic [31:0]    r_addr1;
  logic           r_rw1;
  logic [255:0]   r_wdat1;
  logic [7:0]     r_size1;
  logic [255:0]   r_rdat0;
  logic [255:0]   r_rdat1;

  logic w_done0;
  logic w_done1;
  logic w_acc0;
  logic w_acc1;
  logic w_drop0;
  logic w_drop1;
  logic w_tmo;
  logic w_act;
  logic w_fin;
  logic [255:0] w_cap;

  assign w_done0 = (r_state == S_RESP) && !r_grant;
  assign w_done1 = (r_state == S_RESP) && r_grant;

  // A re-strobe in the completion cycle is accepted: set beats clear.
  assign w_acc0  = req0_strobe_i && (!r_pend[0] || w_done0);
  assign w_acc1  = req1_strobe_i && (!r_pend[1] || w_done1);
  assign w_drop0 = req0_strobe_i && r_pend[0] && !w_done0;
  assign w_drop1 = req1_strobe_i && r_pend[1] && !w_done1;

  assign w_tmo = TO_EN && (r_cnt == TO_LIM);
  assign w_fin = (r_state == S_WAIT) && (dmm_unit_done || w_tmo);
  assign w_cap = dmm_unit_done ? dmm_unit_datain : '0;
  assign w_act = (r_state == S_ISSUE) || (r_state == S_WAIT);

  always_comb begin
    w_next      = r_state;
    w_grant_nxt = r_grant;
    unique case (r_state)
      S_IDLE: begin
        unique case (1'b1)
          (r_pend[0] && r_pend[1]): begin
            w_grant_nxt = !r_ptr;
            w_next      = S_ISSUE;
          end
          (r_pend[0] && !r_pend[1]): begin
            w_grant_nxt = 1'b0;
            w_next      = S_ISSUE;
          end
          (!r_pend[0] && r_pend[1]): begin
            w_grant_nxt = 1'b1;
            w_next      = S_ISSUE;
          end
          default: w_next = S_IDLE;
        endcase
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (dmm_unit_done || w_tmo) begin
          w_next = S_RESP;
        end
      end
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_grant   <= 1'b0;
      r_ptr     <= 1'b0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_rdat0   <= '0;
      r_rdat1   <= '0;
    end else begin
      r_state   <= w_next;
      r_grant   <= w_grant_nxt;
      r_timeout <= w_fin && !dmm_unit_done;
      if ((r_state == S_WAIT) && !w_fin) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_fin && !r_grant) begin
        r_rdat0 <= w_cap;
      end
      if (w_fin && r_grant) begin
        r_rdat1 <= w_cap;
      end
      if (r_state == S_RESP) begin
        r_ptr <= r_grant;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend  <= '0;
      r_addr0 <= '0;
      r_rw0   <= 1'b0;
      r_wdat0 <= '0;
      r_size0 <= '0;
      r_addr1 <= '0;
      r_rw1   <= 1'b0;
      r_wdat1 <= '0;
      r_size1 <= '0;
    end else begin
      if (w_acc0) begin
        r_pend[0] <= 1'b1;
        r_addr0   <= req0_addr_i;
        r_rw0     <= req0_rw_i;
        r_wdat0   <= req0_data_i;
        r_size0   <= req0_size_i;
      end else if (w_done0) begin
        r_pend[0] <= 1'b0;
      end
      if (w_acc1) begin
        r_pend[1] <= 1'b1;
        r_addr1   <= req1_addr_i;
        r_rw1     <= req1_rw_i;
        r_wdat1   <= req1_data_i;
        r_size1   <= req1_size_i;
      end else if (w_done1) begin
        r_pend[1] <= 1'b0;
      end
    end
  end

  assign dmm_unit_strobe  = (r_state == S_ISSUE);
  assign dmm_unit_addr    = !w_act ? '0 : (r_grant ? r_addr1 : r_addr0);
  assign dmm_unit_rw      = w_act && (r_grant ? r_rw1 : r_rw0);
  assign dmm_unit_dataout = !w_act ? '0 : (r_grant ? r_wdat1 : r_wdat0);
  assign dmm_unit_size    = !w_act ? '0 : (r_grant ? r_size1 : r_size0);

  assign req0_done_o = w_done0;
  assign req1_done_o = w_done1;
  assign req0_data_o = r_rdat0;
  assign req1_data_o = r_rdat1;
  assign grant_o     = r_grant;
  assign busy_o      = (r_state != S_IDLE);
  assign timeout_o   = r_timeout;
  assign drop_o      = w_drop0 || w_drop1;

endmodule

// File: tb/tb_dmm_port_arbiter.sv
// Directed bench for dmm_port_arbiter: vector table of single
// transactions plus arbitration, drop and reset sequences.
module tb_dmm_port_arbiter;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_strobe_i, req1_strobe_i;
  logic [31:0]  req0_addr_i, req1_addr_i;
  logic         req0_rw_i, req1_rw_i;
  logic [255:0] req0_data_i, req1_data_i;
  logic [7:0]   req0_size_i, req1_size_i;
  logic         req0_done_o, req1_done_o;
  logic [255:0] req0_data_o, req1_data_o;
  logic         dmm_unit_strobe;
  logic [31:0]  dmm_unit_addr;
  logic         dmm_unit_rw;
  logic [255:0] dmm_unit_dataout;
  logic [7:0]   dmm_unit_size;
  logic         dmm_unit_done;
  logic [255:0] dmm_unit_datain;
  logic         grant_o, busy_o, timeout_o, drop_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmm_port_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_strobe_i(req0_strobe_i), .req0_addr_i(req0_addr_i),
    .req0_rw_i(req0_rw_i), .req0_data_i(req0_data_i),
    .req0_size_i(req0_size_i), .req0_done_o(req0_done_o),
    .req0_data_o(req0_data_o),
    .req1_strobe_i(req1_strobe_i), .req1_addr_i(req1_addr_i),
    .req1_rw_i(req1_rw_i), .req1_data_i(req1_data_i),
    .req1_size_i(req1_size_i), .req1_done_o(req1_done_o),
    .req1_data_o(req1_data_o),
    .dmm_unit_strobe(dmm_unit_strobe), .dmm_unit_addr(dmm_unit_addr),
    .dmm_unit_rw(dmm_unit_rw), .dmm_unit_dataout(dmm_unit_dataout),
    .dmm_unit_size(dmm_unit_size), .dmm_unit_done(dmm_unit_done),
    .dmm_unit_datain(dmm_unit_datain),
    .grant_o(grant_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .drop_o(drop_o)
  );

  typedef struct {
    logic        who;
    logic        rw;
    logic [31:0] addr;
    logic [7:0]  wb;
    logic [7:0]  sz;
    int          dly;
    logic [7:0]  rb;
    logic        tmo;
  } vec_t;

  vec_t vt[5];
  logic [31:0] exp_addr[2];

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic who, input logic s,
                         input logic rw, input logic [31:0] a,
                         input logic [255:0] d, input logic [7:0] sz);
    if (!who) begin
      req0_strobe_i = s; req0_rw_i = rw; req0_addr_i = a;
      req0_data_i = d; req0_size_i = sz;
    end else begin
      req1_strobe_i = s; req1_rw_i = rw; req1_addr_i = a;
      req1_data_i = d; req1_size_i = sz;
    end
  endtask

  task automatic wait_issue(input string nm);
    int n = 0;
    while (!dmm_unit_strobe && n < 10) begin
      step();
      n++;
    end
    chk({nm, "_issue"}, 256'(dmm_unit_strobe), 256'(1));
  endtask

  // From an ISSUE cycle: answer in WAIT cycle 0, land in RESP.
  task automatic respond(input logic [7:0] b);
    step();
    dmm_unit_done = 1'b1;
    dmm_unit_datain = {32{b}};
    step();
    dmm_unit_done = 1'b0;
    dmm_unit_datain = '0;
    #1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_stb"}, 256'(dmm_unit_strobe), 256'(0));
    chk({nm, "_addr"}, 256'(dmm_unit_addr), 256'(0));
    chk({nm, "_rw"}, 256'(dmm_unit_rw), 256'(0));
    chk({nm, "_dout"}, dmm_unit_dataout, 256'(0));
    chk({nm, "_size"}, 256'(dmm_unit_size), 256'(0));
    chk({nm, "_done0"}, 256'(req0_done_o), 256'(0));
    chk({nm, "_done1"}, 256'(req1_done_o), 256'(0));
    chk({nm, "_busy"}, 256'(busy_o), 256'(0));
    chk({nm, "_to"}, 256'(timeout_o), 256'(0));
  endtask

  task automatic run_vec(input vec_t v, input int k);
    logic [255:0] wd;
    logic [255:0] rd;
    string p;
    int n;
    p = $sformatf("v%0d", k);
    wd = {32{v.wb}};
    rd = v.tmo ? 256'(0) : {32{v.rb}};
    set_req(v.who, 1'b1, v.rw, v.addr, wd, v.sz);
    #1;
    chk({p, "_nodrop"}, 256'(drop_o), 256'(0));
    step();
    set_req(v.who, 1'b0, 1'b0, 32'h0, 256'h0, 8'h0);
    #1;
    chk({p, "_t1_stb"}, 256'(dmm_unit_strobe), 256'(0));
    step();
    chk({p, "_t2_stb"}, 256'(dmm_unit_strobe), 256'(1));
    chk({p, "_addr"}, 256'(dmm_unit_addr), 256'(v.addr));
    chk({p, "_rw"}, 256'(dmm_unit_rw), 256'(v.rw));
    chk({p, "_dout"}, dmm_unit_dataout, wd);
    chk({p, "_size"}, 256'(dmm_unit_size), 256'(v.sz));
    chk({p, "_grant"}, 256'(grant_o), 256'(v.who));
    step();
    chk({p, "_wait_stb"}, 256'(dmm_unit_strobe), 256'(0));
    chk({p, "_wait_addr"}, 256'(dmm_unit_addr), 256'(v.addr));
    if (!v.tmo) begin
      repeat (v.dly) step();
      dmm_unit_done = 1'b1;
      dmm_unit_datain = {32{v.rb}};
      step();
      dmm_unit_done = 1'b0;
      dmm_unit_datain = '0;
    end else begin
      n = 0;
      while (!(v.who ? req1_done_o : req0_done_o) && n < 20) begin
        step();
        n++;
      end
      chk({p, "_to_lat"}, 256'(n), 256'(TO));
    end
    chk({p, "_done"}, 256'(v.who ? req1_done_o : req0_done_o), 256'(1));
    chk({p, "_odone"}, 256'(v.who ? req0_done_o : req1_done_o), 256'(0));
    chk({p, "_rdata"}, v.who ? req1_data_o : req0_data_o, rd);
    chk({p, "_to"}, 256'(timeout_o), 256'(v.tmo));
    step();
    chk({p, "_after_done"}, 256'(v.who ? req1_done_o : req0_done_o),
        256'(0));
    chk({p, "_after_to"}, 256'(timeout_o), 256'(0));
    chk({p, "_after_busy"}, 256'(busy_o), 256'(0));
    chk({p, "_hold"}, v.who ? req1_data_o : req0_data_o, rd);
    if (v.tmo) begin
      repeat (2) step();
      dmm_unit_done = 1'b1;
      dmm_unit_datain = '1;
      step();
      dmm_unit_done = 1'b0;
      dmm_unit_datain = '0;
      chk({p, "_late_d0"}, 256'(req0_done_o), 256'(0));
      chk({p, "_late_d1"}, 256'(req1_done_o), 256'(0));
      chk({p, "_late_busy"}, 256'(busy_o), 256'(0));
      step();
      chk({p, "_late2_d1"}, 256'(req1_done_o), 256'(0));
      chk({p, "_late_hold"}, req1_data_o, 256'(0));
    end
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b1, 32'h7000_0010, 8'hA5, 8'h05, 5, 8'h3C, 1'b0};
    vt[1] = '{1'b1, 1'b0, 32'h7000_0080, 8'h00, 8'h02, 0, 8'h5A, 1'b0};
    vt[2] = '{1'b1, 1'b0, 32'h7000_0100, 8'h00, 8'h03, 7, 8'h77, 1'b0};
    vt[3] = '{1'b1, 1'b1, 32'h7000_00C0, 8'h33, 8'h04, 0, 8'h00, 1'b1};
    vt[4] = '{1'b0, 1'b0, 32'h7000_0200, 8'h00, 8'h01, 2, 8'hC3, 1'b0};

    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 256'h0, 8'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 256'h0, 8'h0);
    dmm_unit_done = 1'b0;
    dmm_unit_datain = '0;
    repeat (3) step();
    chk_quiet("rst");
    chk("rst_grant", 256'(grant_o), 256'(0));
    chk("rst_rd0", req0_data_o, 256'(0));
    chk("rst_rd1", req1_data_o, 256'(0));
    rst = 1'b0;
    step();

    // Simultaneous strobes: pointer 0 so req1 goes first.
    set_req(1'b0, 1'b1, 1'b0, 32'h7000_0000, 256'h0, 8'h1);
    set_req(1'b1, 1'b1, 1'b0, 32'h7000_0040, 256'h0, 8'h1);
    step();
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 256'h0, 8'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 256'h0, 8'h0);
    wait_issue("sim_a");
    chk("sim_a_grant", 256'(grant_o), 256'(1));
    chk("sim_a_addr", 256'(dmm_unit_addr), 256'(32'h7000_0040));
    respond(8'h11);
    chk("sim_a_done1", 256'(req1_done_o), 256'(1));
    chk("sim_a_data1", req1_data_o, {32{8'h11}});
    step();
    wait_issue("sim_b");
    chk("sim_b_grant", 256'(grant_o), 256'(0));
    chk("sim_b_addr", 256'(dmm_unit_addr), 256'(32'h7000_0000));
    respond(8'h22);
    chk("sim_b_done0", 256'(req0_done_o), 256'(1));
    chk("sim_b_data0", req0_data_o, {32{8'h22}});
    chk("sim_b_keep1", req1_data_o, {32{8'h11}});
    step();

    // Back-to-back contention with re-strobe in the done cycle.
    exp_addr[0] = 32'h7000_0400;
    exp_addr[1] = 32'h7000_0440;
    set_req(1'b0, 1'b1, 1'b0, exp_addr[0], 256'h0, 8'h2);
    set_req(1'b1, 1'b1, 1'b0, exp_addr[1], 256'h0, 8'h2);
    step();
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 256'h0, 8'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 256'h0, 8'h0);
    for (int r = 0; r < 6; r++) begin
      logic g;
      g = (r % 2 == 0) ? 1'b1 : 1'b0;
      wait_issue($sformatf("rr%0d", r));
      chk($sformatf("rr%0d_grant", r), 256'(grant_o), 256'(g));
      chk($sformatf("rr%0d_addr", r), 256'(dmm_unit_addr),
          256'(exp_addr[g]));
      respond(8'(r + 1));
      chk($sformatf("rr%0d_done", r),
          256'(g ? req1_done_o : req0_done_o), 256'(1));
      if (r < 5) begin
        exp_addr[g] = 32'h7000_1000 + 32'(r * 64);
        set_req(g, 1'b1, 1'b0, exp_addr[g], 256'h0, 8'h2);
        #1;
        chk($sformatf("rr%0d_nodrop", r), 256'(drop_o), 256'(0));
      end
      step();
      set_req(g, 1'b0, 1'b0, 32'h0, 256'h0, 8'h0);
    end
    wait_issue("drain");
    chk("drain_grant", 256'(grant_o), 256'(1));
    chk("drain_addr", 256'(dmm_unit_addr), 256'(exp_addr[1]));
    respond(8'h99);
    chk("drain_done1", 256'(req1_done_o), 256'(1));
    step();

    for (int k = 0; k < 5; k++) begin
      run_vec(vt[k], k);
    end

    // Second strobe while pending is dropped; original request issues.
    set_req(1'b0, 1'b1, 1'b0, 32'h7000_0300, 256'h0, 8'h6);
    step();
    set_req(1'b0, 1'b1, 1'b1, 32'h7000_0999, '1, 8'h7);
    #1;
    chk("drop_pulse", 256'(drop_o), 256'(1));
    step();
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 256'h0, 8'h0);
    #1;
    chk("drop_clear", 256'(drop_o), 256'(0));
    wait_issue("drop");
    chk("drop_addr", 256'(dmm_unit_addr), 256'(32'h7000_0300));
    chk("drop_rw", 256'(dmm_unit_rw), 256'(0));
    chk("drop_size", 256'(dmm_unit_size), 256'(6));
    respond(8'h44);
    chk("drop_done0", 256'(req0_done_o), 256'(1));
    chk("drop_data0", req0_data_o, {32{8'h44}});
    step();

    // Reset in the middle of WAIT.
    set_req(1'b1, 1'b1, 1'b1, 32'h7000_0500, {32{8'h5E}}, 8'h3);
    step();
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 256'h0, 8'h0);
    wait_issue("mrst");
    step();
    step();
    chk("mrst_busy_pre", 256'(busy_o), 256'(1));
    rst = 1'b1;
    #1;
    chk_quiet("mrst");
    chk("mrst_grant", 256'(grant_o), 256'(0));
    chk("mrst_rd0", req0_data_o, 256'(0));
    step();
    rst = 1'b0;
    step();
    dmm_unit_done = 1'b1;
    dmm_unit_datain = '1;
    step();
    dmm_unit_done = 1'b0;
    dmm_unit_datain = '0;
    chk("mrst_stale_d1", 256'(req1_done_o), 256'(0));
    chk("mrst_stale_busy", 256'(busy_o), 256'(0));
    repeat (3) step();
    chk("mrst_idle_stb", 256'(dmm_unit_strobe), 256'(0));
    chk("mrst_idle_busy", 256'(busy_o), 256'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
